// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result, converts it to two BCD digits with a
// sequential double-dabble engine, and drives a multiplexed 2-digit 7-segment display.
module adder_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Z,
    input  logic       Cout,
    input  logic       Load,
    output logic       Busy,
    output logic       Valid,
    output logic [6:0] Seg,
    output logic [1:0] An
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] RMAX = RW'(REFRESH_DIV - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    bin_q, bin_d;
    logic [7:0]    bcd_q, bcd_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          sel_q, sel_d;

    logic [7:0]    adj_s;
    logic [7:0]    bcd_shift_s;
    logic [4:0]    bin_shift_s;

    // Active-low gfedcba pattern for one decimal digit
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // One double-dabble step: add 3 to any nibble >= 5, then shift {bcd, bin} left
    always_comb begin
        adj_s[3:0]  = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
        adj_s[7:4]  = (bcd_q[7:4] >= 4'd5) ? (bcd_q[7:4] + 4'd3) : bcd_q[7:4];
        bcd_shift_s = (adj_s << 1) | {7'd0, bin_q[4]};
        bin_shift_s = {bin_q[3:0], 1'b0};
    end

    // Capture/convert FSM next-state logic
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    bin_d   = {Cout, Z};
                    bcd_d   = 8'd0;
                    cnt_d   = 3'd0;
                    valid_d = 1'b0;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                bcd_d = bcd_shift_s;
                bin_d = bin_shift_s;
                cnt_d = cnt_q + 3'd1;
                // Fifth shift completes the conversion; publish it to the display
                if (cnt_q == 3'd4) begin
                    tens_d  = bcd_shift_s[7:4];
                    ones_d  = bcd_shift_s[3:0];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit refresh divider, free-running regardless of FSM state
    always_comb begin
        if (rcnt_q == RMAX) begin
            rcnt_d = '0;
            sel_d  = ~sel_q;
        end else begin
            rcnt_d = rcnt_q + RW'(1);
            sel_d  = sel_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= 5'd0;
            bcd_q   <= 8'd0;
            cnt_q   <= 3'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            valid_q <= 1'b0;
            rcnt_q  <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            valid_q <= valid_d;
            rcnt_q  <= rcnt_d;
            sel_q   <= sel_d;
        end
    end

    // Digit multiplexing with leading-zero blanking on the tens digit
    always_comb begin
        if (sel_q) begin
            An  = 2'b01;
            Seg = (tens_q == 4'd0) ? 7'b1111111 : seg_decode(tens_q);
        end else begin
            An  = 2'b10;
            Seg = seg_decode(ones_q);
        end
    end

    assign Busy  = (state_q == CONV);
    assign Valid = valid_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Self-checking bench: a cycle-level value model is compared to the DUT every
// cycle, and directed scenarios pin literal display patterns.
module tb_adder_result_display;

    localparam int RDIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] Z = 4'd0;
    logic       Cout = 1'b0;
    logic       Load = 1'b0;
    logic       Busy, Valid;
    logic [6:0] Seg;
    logic [1:0] An;

    int n_cmp = 0;
    int n_err = 0;

    adder_result_display #(.REFRESH_DIV(RDIV)) dut (
        .clk(clk), .reset(reset), .Z(Z), .Cout(Cout), .Load(Load),
        .Busy(Busy), .Valid(Valid), .Seg(Seg), .An(An)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value model: what number is shown, how long the conversion still runs, cycles since reset
    int  m_shown = 0, m_pending = 0, m_left = 0, m_cyc = 0;
    bit  m_valid = 1'b0, m_started = 1'b0;

    always @(posedge clk) begin
        m_started <= 1'b1;
        if (reset) begin
            m_shown <= 0; m_left <= 0; m_valid <= 1'b0; m_cyc <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_shown <= m_pending;
                    m_valid <= 1'b1;
                end
            end else if (Load) begin
                m_pending <= {27'd0, Cout, Z};
                m_left    <= 5;
                m_valid   <= 1'b0;
            end
        end
    end

    bit         e_sel;
    logic [1:0] e_an;
    logic [6:0] e_seg;

    always @(negedge clk) begin
        if (m_started) begin
            e_sel = ((m_cyc / RDIV) % 2) == 1;
            e_an  = e_sel ? 2'b01 : 2'b10;
            if (e_sel) e_seg = (m_shown / 10 == 0) ? 7'b1111111 : seg_of(m_shown / 10);
            else       e_seg = seg_of(m_shown % 10);
            chk("model_busy",  32'(Busy),  32'(m_left > 0));
            chk("model_valid", 32'(Valid), 32'(m_valid));
            chk("model_an",    32'(An),    32'(e_an));
            chk("model_seg",   32'(Seg),   32'(e_seg));
        end
    end

    task automatic do_load(input logic [4:0] v, output int busy_cycles);
        @(negedge clk);
        {Cout, Z} = v;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        busy_cycles = 0;
        while (Busy && busy_cycles < 20) begin
            busy_cycles++;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic wait_slot(input logic [1:0] an_want);
        int k = 0;
        while (An !== an_want && k < 3 * RDIV) begin
            @(negedge clk);
            k++;
        end
        #1;
        chk("slot_reached", 32'(An), 32'(an_want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bc;
        // Reset state and first refresh toggle
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_an", 32'(An), 32'(2'b10));
        chk("rst_seg", 32'(Seg), 32'(7'b1000000));
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_tens_an", 32'(An), 32'(2'b01));
        chk("rst_tens_blank", 32'(Seg), 32'(7'b1111111));

        // Capture 10
        do_load(5'd10, bc);
        chk("c10_busy_len", 32'(bc), 32'd5);
        chk("c10_valid", 32'(Valid), 32'd1);
        chk("c10_model", 32'(m_shown), 32'd10);
        wait_slot(2'b10);
        chk("c10_ones", 32'(Seg), 32'(7'b1000000));
        wait_slot(2'b01);
        chk("c10_tens", 32'(Seg), 32'(7'b1111001));

        // Capture maximum 31
        do_load(5'd31, bc);
        chk("c31_busy_len", 32'(bc), 32'd5);
        wait_slot(2'b01);
        chk("c31_tens", 32'(Seg), 32'(7'b0110000));
        wait_slot(2'b10);
        chk("c31_ones", 32'(Seg), 32'(7'b1111001));

        // Load pulse during conversion is ignored
        @(negedge clk);
        {Cout, Z} = 5'd7;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        bc = 1;
        @(negedge clk);
        {Cout, Z} = 5'd2;
        Load = 1'b1;
        bc++;
        @(negedge clk);
        Load = 1'b0;
        bc++;
        @(negedge clk);
        while (Busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        #1;
        chk("ign_busy_len", 32'(bc), 32'd5);
        repeat (3) @(negedge clk);
        #1;
        chk("ign_no_second", 32'(Busy), 32'd0);
        wait_slot(2'b10);
        chk("ign_ones", 32'(Seg), 32'(7'b1111000));
        wait_slot(2'b01);
        chk("ign_tens_blank", 32'(Seg), 32'(7'b1111111));

        // Reset in the third conversion cycle
        @(negedge clk);
        {Cout, Z} = 5'd25;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(Busy), 32'd0);
        chk("mid_valid", 32'(Valid), 32'd0);
        chk("mid_an", 32'(An), 32'(2'b10));
        chk("mid_seg", 32'(Seg), 32'(7'b1000000));
        do_load(5'd25, bc);
        chk("c25_busy_len", 32'(bc), 32'd5);
        wait_slot(2'b10);
        chk("c25_ones", 32'(Seg), 32'(7'b0010010));
        wait_slot(2'b01);
        chk("c25_tens", 32'(Seg), 32'(7'b0100100));

        // Old value stays on display while a new conversion runs
        do_load(5'd19, bc);
        @(negedge clk);
        {Cout, Z} = 5'd4;
        Load = 1'b1;
        @(negedge clk);
        Load = 1'b0;
        bc = 0;
        while (Busy && bc < 20) begin
            #1;
            chk("hold_seg", 32'(Seg), (An == 2'b10) ? 32'(7'b0010000) : 32'(7'b1111001));
            bc++;
            @(negedge clk);
        end
        #1;
        chk("hold_busy_len", 32'(bc), 32'd5);
        wait_slot(2'b10);
        chk("c4_ones", 32'(Seg), 32'(7'b0011001));
        wait_slot(2'b01);
        chk("c4_tens_blank", 32'(Seg), 32'(7'b1111111));

        // Load held high restarts every six cycles
        @(negedge clk);
        {Cout, Z} = 5'd3;
        Load = 1'b1;
        repeat (14) @(negedge clk);
        Load = 1'b0;
        bc = 0;
        while (Busy && bc < 20) begin
            bc++;
            @(negedge clk);
        end
        #1;
        chk("held_idle", 32'(Busy), 32'd0);
        wait_slot(2'b10);
        chk("held_ones", 32'(Seg), 32'(7'b0110000));
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
